// File: rtl/arb_mux_pkg.sv
// Shared constants and helpers for the arbitrated, registered N-way multiplexer.
package arb_mux_pkg;

    localparam int MODE_SEL = 0;
    localparam int MODE_RR  = 1;

    // Index width; a 1-bit field is kept even when there is a single choice.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/arb_mux_reg_rr_arbiter.sv
// Round-robin arbiter: owns the rotating priority pointer and the wrap-around scan.
module rr_arbiter
    import arb_mux_pkg::*;
#(
    parameter int N    = 4,
    parameter int SELW = idx_w(N)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N-1:0]    req,
    input  logic            advance,
    output logic [SELW-1:0] gnt_idx,
    output logic            gnt_vld
);

    logic [SELW-1:0] r_ptr;
    logic [SELW-1:0] w_cand;
    int              w_idx;

    // Scan from r_ptr upward; wrap is modulo N so non-power-of-two N never visits >= N.
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        w_idx   = 0;
        w_cand  = '0;
        for (int k = 0; k < N; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= N) w_idx = w_idx - N;
            w_cand = SELW'(w_idx);
            if (!gnt_vld && req[w_cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = w_cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (advance) begin
            r_ptr <= (gnt_idx == SELW'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end

endmodule

// File: rtl/arb_mux_reg.sv
// N-way WIDTH-bit mux with per-channel valid/ready and a registered, flow-controlled output.
module arb_mux_reg
    import arb_mux_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SELW  = idx_w(N),
    parameter int MODE  = MODE_SEL
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
    input  logic [SELW-1:0]    sel,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [SELW-1:0]    out_src,
    output logic               sel_err
);

    logic             w_load_en;
    logic             w_gnt_vld;
    logic             w_xfer;
    logic             w_sel_bad;
    logic [SELW-1:0]  w_gnt_idx;
    logic [N-1:0]     w_gnt_oh;
    logic [WIDTH-1:0] w_word;

    logic             r_out_valid;
    logic [WIDTH-1:0] r_out_data;
    logic [SELW-1:0]  r_out_src;
    logic             r_sel_err;

    assign w_load_en = !r_out_valid || out_ready;

    generate
        if (MODE == MODE_RR) begin : g_rr
            rr_arbiter #(.N(N), .SELW(SELW)) u_arb (
                .clk     (clk),
                .rst_n   (rst_n),
                .req     (in_valid),
                .advance (w_xfer),
                .gnt_idx (w_gnt_idx),
                .gnt_vld (w_gnt_vld)
            );
            assign w_sel_bad = 1'b0;
        end else begin : g_sel
            // An out-of-range sel matches no channel, so it grants nothing.
            assign w_gnt_idx = sel;
            assign w_gnt_vld = |w_gnt_oh;
            assign w_sel_bad = !w_gnt_vld;
        end
    endgenerate

    always_comb begin
        w_gnt_oh = '0;
        w_word   = '0;
        for (int i = 0; i < N; i++) begin
            if (w_gnt_idx == SELW'(i)) begin
                w_gnt_oh[i] = 1'b1;
                w_word      = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    assign in_ready = (w_load_en && w_gnt_vld) ? w_gnt_oh : '0;
    assign w_xfer   = |(in_ready & in_valid);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_sel_err   <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_word;
                r_out_src   <= w_gnt_idx;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_load_en && w_sel_bad) r_sel_err <= 1'b1;
        end
    end

    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;
    assign sel_err   = r_sel_err;

endmodule
